// File: rtl/vec_mac.sv
// vec_mac: per-lane multiply-accumulate, one dot product per matrix row per lane.
// Optional: define MAC_SATURATE_EN for a saturating accumulate (default wraps).
module vec_mac_lane #(
  parameter int val_bits = 32,
  parameter int acc_bits = 72
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [val_bits-1:0] vec,
  input  logic                       vec_fifo_empty,
  output logic                       vec_fifo_read,
  input  logic signed [val_bits-1:0] val,
  input  logic                       val_last,
  input  logic                       val_fifo_empty,
  output logic                       val_fifo_read,
  output logic [acc_bits-1:0]        res,
  input  logic                       res_fifo_full,
  output logic                       res_fifo_write,
  output logic [15:0]                rows_done
);
  logic stall, fire, load;
  logic p_valid, p_last, out_pending, first;
  logic signed [2*val_bits-1:0] prod;
  logic signed [acc_bits-1:0] p, acc, out, base, sum;

  assign stall          = out_pending & res_fifo_full;
  assign fire           = ~vec_fifo_empty & ~val_fifo_empty & ~stall;
  assign vec_fifo_read  = fire;
  assign val_fifo_read  = fire;
  assign prod           = vec * val;
  assign base           = first ? '0 : acc;
  assign load           = p_valid & ~stall & p_last;
  assign res_fifo_write = out_pending & ~res_fifo_full;
  assign res            = out;

`ifdef MAC_SATURATE_EN
  localparam logic signed [acc_bits-1:0] acc_max = {1'b0, {(acc_bits-1){1'b1}}};
  localparam logic signed [acc_bits-1:0] acc_min = {1'b1, {(acc_bits-1){1'b0}}};
  logic [acc_bits:0] wide;
  // One guard bit: overflow iff the top two bits of the widened sum disagree.
  assign wide = {base[acc_bits-1], base} + {p[acc_bits-1], p};
  assign sum  = (wide[acc_bits] != wide[acc_bits-1]) ?
                (wide[acc_bits] ? acc_min : acc_max) : wide[acc_bits-1:0];
`else
  assign sum = base + p;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid     <= 1'b0;
      p_last      <= 1'b0;
      p           <= '0;
      acc         <= '0;
      first       <= 1'b1;
      out         <= '0;
      out_pending <= 1'b0;
      rows_done   <= '0;
    end else begin
      // A full result FIFO with a pending result freezes pop, S1 and S2 together.
      if (!stall) begin
        p_valid <= fire;
        if (fire) begin
          p      <= acc_bits'(prod);
          p_last <= val_last;
        end
        if (p_valid) begin
          if (p_last) begin
            out   <= sum;
            first <= 1'b1;
          end else begin
            acc   <= sum;
            first <= 1'b0;
          end
        end
      end
      if (load)                out_pending <= 1'b1;
      else if (res_fifo_write) out_pending <= 1'b0;
      if (res_fifo_write) rows_done <= rows_done + 16'd1;
    end
  end
endmodule

module vec_mac #(
  parameter int channel_num = 4,
  parameter int val_bits    = 32,
  parameter int acc_bits    = 72
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [channel_num*val_bits-1:0] vec,
  input  logic [channel_num-1:0]          vec_fifo_empty,
  output logic [channel_num-1:0]          vec_fifo_read,
  input  logic [channel_num*val_bits-1:0] val,
  input  logic [channel_num-1:0]          val_last,
  input  logic [channel_num-1:0]          val_fifo_empty,
  output logic [channel_num-1:0]          val_fifo_read,
  output logic [channel_num*acc_bits-1:0] res,
  input  logic [channel_num-1:0]          res_fifo_full,
  output logic [channel_num-1:0]          res_fifo_write,
  output logic [channel_num*16-1:0]       rows_done
);
  for (genvar g = 0; g < channel_num; g++) begin : g_lane
    vec_mac_lane #(.val_bits(val_bits), .acc_bits(acc_bits)) u_lane (
      .clk            (clk),
      .rst            (rst),
      .vec            (vec[g*val_bits +: val_bits]),
      .vec_fifo_empty (vec_fifo_empty[g]),
      .vec_fifo_read  (vec_fifo_read[g]),
      .val            (val[g*val_bits +: val_bits]),
      .val_last       (val_last[g]),
      .val_fifo_empty (val_fifo_empty[g]),
      .val_fifo_read  (val_fifo_read[g]),
      .res            (res[g*acc_bits +: acc_bits]),
      .res_fifo_full  (res_fifo_full[g]),
      .res_fifo_write (res_fifo_write[g]),
      .rows_done      (rows_done[g*16 +: 16])
    );
  end
endmodule

// File: tb/tb_vec_mac.sv
// Directed bench for vec_mac: lane-0 FIFO model plus a narrow 8/16-bit instance for overflow.
module tb_vec_mac;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [3:0][31:0] vec_b, val_b;
  logic [3:0]       vec_e, val_e, val_l, res_full, vec_rd, val_rd, res_wr;
  logic [3:0][71:0] res_b;
  logic [3:0][15:0] rows_b;

  logic [7:0]  s_vec, s_val;
  logic        s_ve, s_me, s_last, s_full, s_vrd, s_mrd, s_wr;
  logic [15:0] s_res, s_rows;

  vec_mac #(.channel_num(4), .val_bits(32), .acc_bits(72)) dut (
    .clk(clk), .rst(rst),
    .vec(vec_b), .vec_fifo_empty(vec_e), .vec_fifo_read(vec_rd),
    .val(val_b), .val_last(val_l), .val_fifo_empty(val_e), .val_fifo_read(val_rd),
    .res(res_b), .res_fifo_full(res_full), .res_fifo_write(res_wr),
    .rows_done(rows_b)
  );

  vec_mac #(.channel_num(1), .val_bits(8), .acc_bits(16)) dut_s (
    .clk(clk), .rst(rst),
    .vec(s_vec), .vec_fifo_empty(s_ve), .vec_fifo_read(s_vrd),
    .val(s_val), .val_last(s_last), .val_fifo_empty(s_me), .val_fifo_read(s_mrd),
    .res(s_res), .res_fifo_full(s_full), .res_fifo_write(s_wr),
    .rows_done(s_rows)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int vq[$];
  int mq[$];
  bit lq[$];
  logic signed [71:0] got[$];
  int got_cyc[$];

  task automatic upd_heads();
    vec_e[0] = (vq.size() == 0);
    val_e[0] = (mq.size() == 0);
    vec_b[0] = (vq.size() != 0) ? vq[0] : 0;
    val_b[0] = (mq.size() != 0) ? mq[0] : 0;
    val_l[0] = (lq.size() != 0) ? lq[0] : 1'b0;
  endtask

  task automatic push(input int v, input int m, input bit l);
    vq.push_back(v);
    mq.push_back(m);
    lq.push_back(l);
  endtask

  // Inputs change at posedge+1; outputs are sampled at posedge+2.
  task automatic step();
    logic vr, mr;
    #1;
    vr = vec_rd[0];
    mr = val_rd[0];
    checks++;
    if (vr !== mr) begin
      errors++;
      $display("FAIL pop_pair cyc=%0d vec_read=%b val_read=%b required equal", cyc, vr, mr);
    end
    if (vr | mr) rd_cnt++;
    if (res_wr[0]) begin
      wr_cnt++;
      got.push_back($signed(res_b[0]));
      got_cyc.push_back(cyc);
    end
    if (vr && lq.size() != 0 && lq[0]) last_pop_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (vr && vq.size() != 0) void'(vq.pop_front());
    if (mr && mq.size() != 0) begin
      void'(mq.pop_front());
      void'(lq.pop_front());
    end
    upd_heads();
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (got.size() < n) begin
      errors++;
      $display("FAIL timeout results=%0d required %0d", got.size(), n);
    end
    repeat (3) step();
  endtask

  task automatic check_rows(input string name, input logic [15:0] exp);
    checks++;
    if (rows_b[0] !== exp) begin
      errors++;
      $display("FAIL %s rows_done=%0d required %0d", name, rows_b[0], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (vec_rd !== 4'b0 || val_rd !== 4'b0 || res_wr !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes rd=%b/%b wr=%b required 0", vec_rd, val_rd, res_wr);
    end
    checks++;
    if (res_b !== '0) begin
      errors++;
      $display("FAIL reset_res res=%h required 0", res_b);
    end
    checks++;
    if (rows_b !== '0) begin
      errors++;
      $display("FAIL reset_rows rows_done=%h required 0", rows_b);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_row();
    got.delete(); got_cyc.delete();
    push(1, 4, 1'b0); push(2, 5, 1'b0); push(3, 6, 1'b1);
    upd_heads();
    run_until(1, 20);
    checks++;
    if (got.size() != 1 || got[0] !== 72'sd32) begin
      errors++;
      $display("FAIL row_result n=%0d res=%0d required 1 x 32", got.size(),
               (got.size() != 0) ? got[0] : 72'sd0);
    end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] - last_pop_cyc != 2) begin
      errors++;
      $display("FAIL row_latency latency=%0d required 2",
               (got_cyc.size() != 0) ? got_cyc[0] - last_pop_cyc : -1);
    end
    check_rows("row_rows", 16'd1);
  endtask

  task automatic test_vec_empty();
    got.delete(); got_cyc.delete();
    rd_cnt = 0;
    mq.push_back(7); lq.push_back(1'b1);
    upd_heads();
    repeat (10) step();
    checks++;
    if (rd_cnt != 0 || got.size() != 0) begin
      errors++;
      $display("FAIL vec_empty reads=%0d writes=%0d required 0 0", rd_cnt, got.size());
    end
    vq.push_back(3);
    upd_heads();
    run_until(1, 20);
    checks++;
    if (got.size() != 1 || got[0] !== 72'sd21) begin
      errors++;
      $display("FAIL vec_refill n=%0d res=%0d required 1 x 21", got.size(),
               (got.size() != 0) ? got[0] : 72'sd0);
    end
    check_rows("vec_empty_rows", 16'd2);
  endtask

  task automatic test_back_to_back();
    logic signed [71:0] exp [4];
    exp[0] = 6; exp[1] = -7; exp[2] = 0; exp[3] = 25;
    got.delete(); got_cyc.delete();
    push(2, 3, 1'b1); push(-1, 7, 1'b1); push(0, 9, 1'b1); push(5, 5, 1'b1);
    upd_heads();
    run_until(4, 20);
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL b2b_count writes=%0d required 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp[i] || got_cyc[i] != got_cyc[0] + i) begin
          errors++;
          $display("FAIL b2b_%0d res=%0d at +%0d required %0d at +%0d",
                   i, got[i], got_cyc[i] - got_cyc[0], exp[i], i);
        end
      end
    end
    check_rows("b2b_rows", 16'd6);
  endtask

  task automatic test_full_stall();
    int bad = 0;
    int rel;
    logic signed [71:0] exp [3];
    exp[0] = 4; exp[1] = 1; exp[2] = 9;
    got.delete(); got_cyc.delete();
    res_full[0] = 1'b1;
    push(2, 2, 1'b1); push(1, 1, 1'b1); push(3, 3, 1'b1);
    upd_heads();
    repeat (3) step();
    rd_cnt = 0; wr_cnt = 0;
    repeat (10) begin
      step();
      if (res_b[0] !== 72'd4) bad++;
    end
    checks++;
    if (rd_cnt != 0 || wr_cnt != 0) begin
      errors++;
      $display("FAIL stall_idle reads=%0d writes=%0d required 0 0", rd_cnt, wr_cnt);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_res_stable unstable_cycles=%0d required 0 (res=4)", bad);
    end
    res_full[0] = 1'b0;
    rel = cyc;
    run_until(3, 20);
    checks++;
    if (got.size() != 3 || got[0] !== exp[0] || got[1] !== exp[1] || got[2] !== exp[2]) begin
      errors++;
      $display("FAIL stall_release n=%0d first=%0d required 3 results 4,1,9", got.size(),
               (got.size() != 0) ? got[0] : 72'sd0);
    end
    checks++;
    if (got_cyc.size() == 0 || got_cyc[0] != rel) begin
      errors++;
      $display("FAIL stall_first_write cyc=%0d required %0d",
               (got_cyc.size() != 0) ? got_cyc[0] : -1, rel);
    end
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL stall_resume left=%0d required 0", vq.size());
    end
    check_rows("stall_rows", 16'd9);
  endtask

  task automatic test_reset_mid_row();
    got.delete(); got_cyc.delete();
    push(5, 5, 1'b0); push(6, 6, 1'b0);
    upd_heads();
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    push(3, 3, 1'b1);
    upd_heads();
    run_until(1, 20);
    checks++;
    if (got.size() != 1 || got[0] !== 72'sd9) begin
      errors++;
      $display("FAIL reset_mid_row n=%0d res=%0d required 1 x 9", got.size(),
               (got.size() != 0) ? got[0] : 72'sd0);
    end
    check_rows("reset_mid_rows", 16'd1);
  endtask

  task automatic sat_row(input string name, input int n, input logic signed [15:0] exp);
    logic signed [15:0] r = '0;
    int seen = 0;
    s_vec = 8'd127; s_val = 8'd127; s_ve = 1'b0; s_me = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_last = (i == n - 1);
      @(posedge clk);
      #1;
    end
    s_ve = 1'b1; s_me = 1'b1; s_last = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (s_wr) begin
        seen++;
        r = s_res;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 1 || r !== exp) begin
      errors++;
      $display("FAIL %s writes=%0d res=%0d required 1 x %0d", name, seen, r, exp);
    end
  endtask

  task automatic test_overflow();
    sat_row("sat_two", 2, 16'sd32258);
`ifdef MAC_SATURATE_EN
    sat_row("sat_three", 3, 16'sd32767);
`else
    sat_row("wrap_three", 3, -16'sd17149);
`endif
  endtask

  task automatic test_lane_isolation();
    checks++;
    if (rows_b[3:1] !== '0 || vec_rd[3:1] !== 3'b0 || res_wr[3:1] !== 3'b0) begin
      errors++;
      $display("FAIL lane_isolation rows=%h rd=%b wr=%b required 0", rows_b[3:1], vec_rd[3:1], res_wr[3:1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    res_full = '0;
    vec_e = '1; val_e = '1; val_l = '0; vec_b = '0; val_b = '0;
    s_vec = '0; s_val = '0; s_ve = 1'b1; s_me = 1'b1; s_last = 1'b0; s_full = 1'b0;
    upd_heads();
    @(posedge clk);
    #1;
    test_reset();
    test_row();
    test_vec_empty();
    test_back_to_back();
    test_full_stall();
    test_reset_mid_row();
    test_overflow();
    test_lane_isolation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
